stroke_sequencer: RTL

Walks the glyph stroke memory in order and streams every pen position to the motion controller over a valid/ready handshake. For each stroke it emits a pen-up travel move to the first point, then every drawing point, then a pen-up lift at the last point. It drives the stroke index `m` and point index `n` into the stroke memory and consumes that memory's asynchronous-read outputs. It sits between the glyph memory and the XYZ motion planner.

---
 rtl/stroke_sequencer_if.sv | 21 ++
 rtl/stroke_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/stroke_sequencer_if.sv
// Point stream from the stroke sequencer to the XYZ motion planner.
// The master drives the point; the slave answers with pt_ready.
interface stroke_sequencer_if;
    logic       pt_valid;
    logic       pt_ready;
    logic [9:0] pt_x;
    logic [9:0] pt_y;
    logic [8:0] pt_z;
    logic       pt_pen_up;
    logic       pt_last;

    modport master (
        output pt_valid, pt_x, pt_y, pt_z, pt_pen_up, pt_last,
        input  pt_ready
    );

    modport slave (
        input  pt_valid, pt_x, pt_y, pt_z, pt_pen_up, pt_last,
        output pt_ready
    );
endinterface

// File: rtl/stroke_sequencer.sv
// Walks the glyph stroke memory and streams travel, drawing and lift points
// for every stroke to the motion planner over a valid/ready handshake.
module stroke_sequencer #(
    parameter logic [8:0] Z_UP = 9'd500
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [6:0]                 num_strokes,
    output logic [6:0]                 m,
    output logic [6:0]                 n,
    input  logic [9:0]                 spox,
    input  logic [9:0]                 spoy,
    input  logic [8:0]                 spoz,
    input  logic [6:0]                 lenth,
    stroke_sequencer_if.master         pt,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN    = 3'd1,
        ST_TRAVEL = 3'd2,
        ST_DRAW_F = 3'd3,
        ST_DRAW_S = 3'd4,
        ST_LIFT   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t     state_r;
    logic [6:0] ns_r;
    logic [6:0] len_r;
    logic       accept_s;
    logic [7:0] m_next_s;
    logic       last_stroke_s;

    // Widened compare: idx+1 against len avoids evaluating len-1 at zero.
    function automatic logic is_last(input logic [6:0] idx, input logic [6:0] len);
        return (({1'b0, idx} + 8'd1) == {1'b0, len});
    endfunction

    assign accept_s      = pt.pt_valid && pt.pt_ready;
    assign m_next_s      = {1'b0, m} + 8'd1;
    assign last_stroke_s = (m_next_s == {1'b0, ns_r});

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ns_r         <= 7'd0;
            len_r        <= 7'd0;
            m            <= 7'd0;
            n            <= 7'd0;
            pt.pt_valid  <= 1'b0;
            pt.pt_x      <= 10'd0;
            pt.pt_y      <= 10'd0;
            pt.pt_z      <= 9'd0;
            pt.pt_pen_up <= 1'b0;
            pt.pt_last   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (abort) begin
            state_r      <= ST_IDLE;
            m            <= 7'd0;
            n            <= 7'd0;
            pt.pt_valid  <= 1'b0;
            pt.pt_pen_up <= 1'b0;
            pt.pt_last   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ns_r <= num_strokes;
                        m    <= 7'd0;
                        n    <= 7'd0;
                        busy <= 1'b1;
                        if (num_strokes == 7'd0) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= ST_LEN;
                        end
                    end
                end
                ST_LEN: begin
                    len_r <= lenth;
                    if (lenth == 7'd0) begin
                        m <= m_next_s[6:0];
                        if (last_stroke_s) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end
                    end else begin
                        pt.pt_x      <= spox;
                        pt.pt_y      <= spoy;
                        pt.pt_z      <= Z_UP;
                        pt.pt_pen_up <= 1'b1;
                        pt.pt_valid  <= 1'b1;
                        state_r      <= ST_TRAVEL;
                    end
                end
                ST_TRAVEL: begin
                    if (accept_s) begin
                        pt.pt_valid <= 1'b0;
                        state_r     <= ST_DRAW_F;
                    end
                end
                ST_DRAW_F: begin
                    pt.pt_x      <= spox;
                    pt.pt_y      <= spoy;
                    pt.pt_z      <= spoz;
                    pt.pt_pen_up <= 1'b0;
                    pt.pt_last   <= is_last(n, len_r);
                    pt.pt_valid  <= 1'b1;
                    state_r      <= ST_DRAW_S;
                end
                ST_DRAW_S: begin
                    if (accept_s) begin
                        if (pt.pt_last) begin
                            // Lift reuses the last drawing point's x/y.
                            pt.pt_z      <= Z_UP;
                            pt.pt_pen_up <= 1'b1;
                            pt.pt_last   <= 1'b0;
                            state_r      <= ST_LIFT;
                        end else begin
                            pt.pt_valid <= 1'b0;
                            n           <= n + 7'd1;
                            state_r     <= ST_DRAW_F;
                        end
                    end
                end
                ST_LIFT: begin
                    if (accept_s) begin
                        pt.pt_valid <= 1'b0;
                        m           <= m_next_s[6:0];
                        n           <= 7'd0;
                        if (last_stroke_s) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= ST_LEN;
                        end
                    end
                end
                ST_DONE: begin
                    m       <= 7'd0;
                    n       <= 7'd0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    pt.pt_valid  <= 1'b0;
                    pt.pt_pen_up <= 1'b0;
                    pt.pt_last   <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
